param_datapath: RTL and testbench

PARAM_DATAPATH -- requirements
Module: param_datapath

---
 rtl/param_datapath_pkg.sv | 31 +++
 rtl/alu.sv | 30 +++
 rtl/dp_ret_stack.sv | 50 +++++
 rtl/param_datapath.sv | 187 ++++++++++++++++++
 tb/tb_param_datapath.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_datapath_pkg.sv
// Shared encodings for param_datapath: PC sequencing modes, ZN flag codes,
// ALU opcodes and the opcodes that drive the index register.
package param_datapath_pkg;

    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_JMP = 2'b01,
        PC_BR  = 2'b10,
        PC_RET = 2'b11
    } pc_mode_e;

    localparam logic [1:0] ZN_NONE = 2'b00;
    localparam logic [1:0] ZN_NEG  = 2'b01;
    localparam logic [1:0] ZN_ZERO = 2'b10;

    // ALU opcodes: a = ALU input register, b = selected accumulator
    localparam logic [4:0] OP_PASS = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_SHR  = 5'b01000;

    localparam logic [4:0] OP_INDR_LD   = 5'b11101;
    localparam logic [4:0] OP_INDR_ADD0 = 5'b11000;
    localparam logic [4:0] OP_INDR_ADD1 = 5'b11001;

endpackage

// File: rtl/alu.sv
// Accumulator ALU: combines the ALU input register (a) with the selected
// accumulator (b). Opcodes without an ALU meaning return b unchanged.
module alu
    import param_datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [4:0]               opcode,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);

    always_comb begin
        y = b;
        case (opcode)
            OP_PASS: y = a;
            OP_ADD:  y = b + a;
            OP_SUB:  y = b - a;
            OP_AND:  y = b & a;
            OP_OR:   y = b | a;
            OP_XOR:  y = b ^ a;
            OP_NOT:  y = ~a;
            OP_SHL:  y = b <<< 1;
            OP_SHR:  y = b >>> 1;
            default: y = b;
        endcase
    end

endmodule

// File: rtl/dp_ret_stack.sv
// LIFO return-address stack. Overflowing push / underflowing pop are dropped
// and flagged with a one-cycle err pulse; pop_data always shows the top entry.
module dp_ret_stack #(
    parameter int PC_W        = 11,
    parameter int STACK_DEPTH = 8
) (
    input  logic            CLOCK,
    input  logic            RESETn,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] pop_data,
    output logic            full,
    output logic            empty,
    output logic            err
);

    localparam int SPW = $clog2(STACK_DEPTH);
    localparam logic [SPW:0] DEPTH_CNT = (SPW + 1)'(STACK_DEPTH);
    localparam logic [SPW:0] ONE_CNT   = (SPW + 1)'(1);

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [SPW:0]    count_q;
    logic [SPW-1:0]  top_idx;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign top_idx  = SPW'(count_q - ONE_CNT);
    assign pop_data = mem[top_idx];

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            count_q <= '0;
            err     <= 1'b0;
        end else begin
            err <= (push && full) || (pop && empty);
            if (push && !full)
                count_q <= count_q + ONE_CNT;
            else if (pop && !empty)
                count_q <= count_q - ONE_CNT;
        end
    end

    // Entry storage carries no reset; the pointer alone defines validity
    always_ff @(posedge CLOCK) begin
        if (push && !full)
            mem[count_q[SPW-1:0]] <= push_data;
    end

endmodule

// File: rtl/param_datapath.sv
// Program-counter sequencer, NACC-entry accumulator bank with ALU, and index
// register. Define PARAM_DATAPATH_RET_STACK_EN to enable CALL/return support.
module param_datapath
    import param_datapath_pkg::*;
#(
    parameter  int DATA_W      = 16,
    parameter  int PC_W        = 11,
    parameter  int NACC        = 4,
    parameter  int STACK_DEPTH = 8,
    localparam int AW          = (NACC > 1) ? $clog2(NACC) : 1
) (
    input  logic              CLOCK,
    input  logic              RESETn,
    input  logic              HOLDn,
    input  logic              EN_PC,
    input  logic [1:0]        PC_MODE,
    input  logic              CALL,
    input  logic [4:0]        OPCODE,
    input  logic [PC_W-1:0]   OPERAND,
    input  logic              SEL_OP_MEM,
    input  logic              EN_IN,
    input  logic              EN_ACC,
    input  logic [AW-1:0]     ACC_SEL,
    input  logic              EN_INDR,
    input  logic [DATA_W-1:0] PRDATA,
    output logic [PC_W-1:0]   PC,
    output logic [DATA_W-1:0] ACC,
    output logic [1:0]        ZN,
    output logic [7:0]        INDR,
    output logic              PC_OF,
    output logic              PC_UF,
    output logic              STK_FULL,
    output logic              STK_EMPTY,
    output logic              STK_ERR
);

`ifdef PARAM_DATAPATH_RET_STACK_EN
    localparam logic STACK_EN = 1'b1;
`else
    localparam logic STACK_EN = 1'b0;
`endif

    logic [PC_W-1:0]          pc_q, pc_d, stk_data;
    logic [PC_W:0]            inc_sum, br_sum;
    logic                     pc_of_p1, pc_uf_p1, of_d, uf_d;
    logic                     push, pop, stk_full, stk_empty, stk_err;
    logic signed [DATA_W-1:0] acc_q [NACC];
    logic signed [DATA_W-1:0] in_q, alu_y, acc_sel_v;
    logic [AW-1:0]            sel;
    logic [1:0]               zn_p1;
    logic [7:0]               indr_q, op8;

    function automatic logic signed [DATA_W-1:0] sext_operand(input logic [PC_W-1:0] v);
        return DATA_W'($signed(v));
    endfunction

    function automatic logic [1:0] zn_of(input logic signed [DATA_W-1:0] v);
        if (v == '0)
            return ZN_ZERO;
        if (v[DATA_W-1])
            return ZN_NEG;
        return ZN_NONE;
    endfunction

    // Bit PC_W of the branch sum is a carry/borrow; the offset sign says which
    assign inc_sum = {1'b0, pc_q} + {{PC_W{1'b0}}, 1'b1};
    assign br_sum  = {1'b0, pc_q} + {OPERAND[PC_W-1], OPERAND};

    always_comb begin
        pc_d = pc_q;
        of_d = 1'b0;
        uf_d = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        if (EN_PC && HOLDn) begin
            case (pc_mode_e'(PC_MODE))
                PC_INC: {of_d, pc_d} = inc_sum;
                PC_JMP: begin
                    pc_d = OPERAND;
                    push = STACK_EN & CALL;
                end
                PC_BR: begin
                    pc_d = br_sum[PC_W-1:0];
                    of_d = br_sum[PC_W] & ~OPERAND[PC_W-1];
                    uf_d = br_sum[PC_W] & OPERAND[PC_W-1];
                end
                PC_RET: begin
                    pop = STACK_EN;
                    if (STACK_EN && !stk_empty)
                        pc_d = stk_data;
                    else
                        {of_d, pc_d} = inc_sum;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            pc_q     <= '0;
            pc_of_p1 <= 1'b0;
            pc_uf_p1 <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_of_p1 <= of_d;
            pc_uf_p1 <= uf_d;
        end
    end

    dp_ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLOCK     (CLOCK),
        .RESETn    (RESETn),
        .push      (push),
        .pop       (pop),
        .push_data (inc_sum[PC_W-1:0]),
        .pop_data  (stk_data),
        .full      (stk_full),
        .empty     (stk_empty),
        .err       (stk_err)
    );

    assign sel       = (NACC > 1) ? ACC_SEL : '0;
    assign acc_sel_v = acc_q[sel];

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (OPCODE),
        .a      (in_q),
        .b      (acc_sel_v),
        .y      (alu_y)
    );

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            in_q <= '0;
        end else if (EN_IN) begin
            in_q <= SEL_OP_MEM ? sext_operand(OPERAND) : $signed(PRDATA);
        end
    end

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NACC; i++)
                acc_q[i] <= '0;
        end else if (EN_ACC) begin
            acc_q[sel] <= alu_y;
        end
    end

    // ZN reflects the accumulator as it stood before this edge
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn)
            zn_p1 <= ZN_NONE;
        else
            zn_p1 <= zn_of(acc_sel_v);
    end

    assign op8 = 8'(OPERAND);

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            indr_q <= '0;
        end else if (EN_INDR) begin
            case (OPCODE)
                OP_INDR_LD:   indr_q <= PRDATA[7:0];
                OP_INDR_ADD0,
                OP_INDR_ADD1: indr_q <= indr_q + op8;
                default:      indr_q <= indr_q;
            endcase
        end
    end

    assign PC        = pc_q;
    assign ACC       = acc_sel_v;
    assign ZN        = zn_p1;
    assign INDR      = indr_q;
    assign PC_OF     = pc_of_p1;
    assign PC_UF     = pc_uf_p1;
    assign STK_FULL  = stk_full;
    assign STK_EMPTY = stk_empty;
    assign STK_ERR   = stk_err;

endmodule

// File: tb/tb_param_datapath.sv
// Bench for param_datapath: directed corner cases plus randomized traffic
// against an arithmetic reference model. Honors PARAM_DATAPATH_RET_STACK_EN.
module tb_param_datapath;
    import param_datapath_pkg::*;

    localparam int DATA_W = 16, PC_W = 11, NACC = 4, STACK_DEPTH = 8, AW = 2;
    localparam int PC_MOD = 1 << PC_W;
    localparam int DMASK  = (1 << DATA_W) - 1;
`ifdef PARAM_DATAPATH_RET_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic              CLOCK = 1'b0, RESETn, HOLDn, EN_PC, CALL, SEL_OP_MEM, EN_IN, EN_ACC, EN_INDR;
    logic [1:0]        PC_MODE;
    logic [4:0]        OPCODE;
    logic [PC_W-1:0]   OPERAND;
    logic [AW-1:0]     ACC_SEL;
    logic [DATA_W-1:0] PRDATA;
    logic [PC_W-1:0]   PC;
    logic [DATA_W-1:0] ACC;
    logic [1:0]        ZN;
    logic [7:0]        INDR;
    logic              PC_OF, PC_UF, STK_FULL, STK_EMPTY, STK_ERR;

    param_datapath #(.DATA_W(DATA_W), .PC_W(PC_W), .NACC(NACC), .STACK_DEPTH(STACK_DEPTH)) dut (
        .CLOCK(CLOCK), .RESETn(RESETn), .HOLDn(HOLDn), .EN_PC(EN_PC), .PC_MODE(PC_MODE),
        .CALL(CALL), .OPCODE(OPCODE), .OPERAND(OPERAND), .SEL_OP_MEM(SEL_OP_MEM),
        .EN_IN(EN_IN), .EN_ACC(EN_ACC), .ACC_SEL(ACC_SEL), .EN_INDR(EN_INDR), .PRDATA(PRDATA),
        .PC(PC), .ACC(ACC), .ZN(ZN), .INDR(INDR), .PC_OF(PC_OF), .PC_UF(PC_UF),
        .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .STK_ERR(STK_ERR));

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0, n_bad = 0;

    // Reference model state
    int m_pc, m_in, m_indr;
    int m_acc [NACC];
    bit m_of, m_uf, m_err;
    bit [1:0] m_zn;
    int m_stk [$];

    task automatic model_reset();
        m_pc = 0; m_in = 0; m_indr = 0; m_of = 0; m_uf = 0; m_err = 0; m_zn = 2'b00;
        for (int i = 0; i < NACC; i++) m_acc[i] = 0;
        m_stk.delete();
    endtask

    function automatic int alu_ref(int op, int a, int b);
        case (op)
            OP_PASS: return a;
            OP_ADD:  return (b + a) & DMASK;
            OP_SUB:  return (b - a) & DMASK;
            OP_AND:  return b & a;
            OP_OR:   return b | a;
            OP_XOR:  return b ^ a;
            OP_NOT:  return (~a) & DMASK;
            OP_SHL:  return (b << 1) & DMASK;
            OP_SHR:  return (b >> 1) | (b & (1 << (DATA_W - 1)));
            default: return b;
        endcase
    endfunction

    function automatic int signed_operand(int v);
        return (v >= PC_MOD / 2) ? v - PC_MOD : v;
    endfunction

    task automatic model_step();
        int sel, a_old, t;
        sel   = int'(ACC_SEL);
        a_old = m_acc[sel];
        m_zn  = (a_old == 0) ? 2'b10 : ((((a_old >> (DATA_W - 1)) & 1) != 0) ? 2'b01 : 2'b00);
        m_of = 0; m_uf = 0; m_err = 0;
        if (EN_PC && HOLDn) begin
            case (PC_MODE)
                2'b00: begin t = m_pc + 1; m_of = (t == PC_MOD); m_pc = t % PC_MOD; end
                2'b01: begin
                    if (STK_EN && CALL) begin
                        if (m_stk.size() == STACK_DEPTH) m_err = 1;
                        else m_stk.push_back((m_pc + 1) % PC_MOD);
                    end
                    m_pc = int'(OPERAND);
                end
                2'b10: begin
                    t = m_pc + signed_operand(int'(OPERAND));
                    m_of = (t >= PC_MOD); m_uf = (t < 0);
                    m_pc = (t + PC_MOD) % PC_MOD;
                end
                default: begin
                    if (STK_EN && m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_err = STK_EN; t = m_pc + 1; m_of = (t == PC_MOD); m_pc = t % PC_MOD; end
                end
            endcase
        end
        if (EN_ACC) m_acc[sel] = alu_ref(int'(OPCODE), m_in, a_old);
        if (EN_IN) m_in = SEL_OP_MEM ? (signed_operand(int'(OPERAND)) & DMASK) : int'(PRDATA);
        if (EN_INDR) begin
            if (OPCODE == 5'b11101) m_indr = int'(PRDATA) & 255;
            else if (OPCODE == 5'b11000 || OPCODE == 5'b11001) m_indr = (m_indr + (int'(OPERAND) & 255)) & 255;
        end
    endtask

    task automatic idle();
        HOLDn = 1; EN_PC = 0; PC_MODE = 2'b00; CALL = 0; OPCODE = '0; OPERAND = '0;
        SEL_OP_MEM = 0; EN_IN = 0; EN_ACC = 0; ACC_SEL = '0; EN_INDR = 0; PRDATA = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic jump(input int target);
        idle(); EN_PC = 1; PC_MODE = 2'b01; OPERAND = PC_W'(target); tick();
    endtask

    task automatic test_reset();
        idle(); RESETn = 0; model_reset();
        repeat (2) @(posedge CLOCK);
        #1;
        n_cmp++; if (PC !== 11'd0) begin n_bad++; $display("FAIL reset_pc: got %0h expected 0", PC); end
        n_cmp++; if (ACC !== 16'd0) begin n_bad++; $display("FAIL reset_acc: got %0h expected 0", ACC); end
        n_cmp++; if (ZN !== 2'b00) begin n_bad++; $display("FAIL reset_zn: got %b expected 00", ZN); end
        n_cmp++; if (INDR !== 8'd0) begin n_bad++; $display("FAIL reset_indr: got %0h expected 0", INDR); end
        n_cmp++; if ({PC_OF, PC_UF, STK_ERR, STK_FULL, STK_EMPTY} !== 5'b00001) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 00001", {PC_OF, PC_UF, STK_ERR, STK_FULL, STK_EMPTY});
        end
        RESETn = 1;
    endtask

    task automatic test_pc_wrap();
        jump(2047);
        n_cmp++; if (PC !== 11'd2047) begin n_bad++; $display("FAIL jump_abs: got %0d expected 2047", PC); end
        idle(); EN_PC = 1; PC_MODE = 2'b00; tick();
        n_cmp++; if ({PC_OF, PC} !== {1'b1, 11'd0}) begin n_bad++; $display("FAIL inc_wrap: got of=%b pc=%0d expected of=1 pc=0", PC_OF, PC); end
        idle(); tick();
        n_cmp++; if ({PC_OF, PC} !== {1'b0, 11'd0}) begin n_bad++; $display("FAIL of_pulse: got of=%b pc=%0d expected of=0 pc=0", PC_OF, PC); end
    endtask

    task automatic test_branch();
        jump(5);
        idle(); EN_PC = 1; PC_MODE = 2'b10; OPERAND = 11'h7F8; tick();
        n_cmp++; if ({PC_UF, PC_OF, PC} !== {2'b10, 11'd2045}) begin n_bad++; $display("FAIL br_under: got uf=%b of=%b pc=%0d expected uf=1 of=0 pc=2045", PC_UF, PC_OF, PC); end
        idle(); tick();
        n_cmp++; if (PC_UF !== 1'b0) begin n_bad++; $display("FAIL uf_pulse: got %b expected 0", PC_UF); end
        jump(2040);
        idle(); EN_PC = 1; PC_MODE = 2'b10; OPERAND = 11'd10; tick();
        n_cmp++; if ({PC_UF, PC_OF, PC} !== {2'b01, 11'd2}) begin n_bad++; $display("FAIL br_over: got uf=%b of=%b pc=%0d expected uf=0 of=1 pc=2", PC_UF, PC_OF, PC); end
    endtask

    task automatic test_acc();
        idle(); ACC_SEL = 2; EN_IN = 1; SEL_OP_MEM = 1; OPERAND = 11'h7FF; tick();
        idle(); ACC_SEL = 2; EN_ACC = 1; OPCODE = OP_PASS; tick();
        n_cmp++; if (ACC !== 16'hFFFF) begin n_bad++; $display("FAIL acc_pass: got %0h expected ffff", ACC); end
        n_cmp++; if (ZN !== 2'b10) begin n_bad++; $display("FAIL zn_latency: got %b expected 10", ZN); end
        idle(); ACC_SEL = 2; tick();
        n_cmp++; if (ZN !== 2'b01) begin n_bad++; $display("FAIL zn_neg: got %b expected 01", ZN); end
        for (int s = 0; s < NACC; s++) begin
            if (s == 2) continue;
            ACC_SEL = AW'(s); #1;
            n_cmp++; if (ACC !== 16'd0) begin n_bad++; $display("FAIL acc_other%0d: got %0h expected 0", s, ACC); end
        end
        idle(); ACC_SEL = 1; EN_IN = 1; SEL_OP_MEM = 0; PRDATA = 16'h0003; tick();
        idle(); ACC_SEL = 1; EN_ACC = 1; OPCODE = OP_ADD; tick();
        idle(); ACC_SEL = 1; EN_ACC = 1; OPCODE = OP_SUB; tick();
        idle(); ACC_SEL = 1; tick();
        n_cmp++; if ({ZN, ACC} !== {2'b10, 16'd0}) begin n_bad++; $display("FAIL acc_addsub: got zn=%b acc=%0h expected zn=10 acc=0", ZN, ACC); end
    endtask

    task automatic test_indr();
        idle(); EN_INDR = 1; OPCODE = 5'b11101; PRDATA = 16'hA5C3; tick();
        n_cmp++; if (INDR !== 8'hC3) begin n_bad++; $display("FAIL indr_load: got %0h expected c3", INDR); end
        idle(); EN_INDR = 1; OPCODE = 5'b11000; OPERAND = 11'h050; tick();
        n_cmp++; if (INDR !== 8'h13) begin n_bad++; $display("FAIL indr_add0: got %0h expected 13", INDR); end
        idle(); EN_INDR = 1; OPCODE = 5'b11001; OPERAND = 11'h7FF; tick();
        n_cmp++; if (INDR !== 8'h12) begin n_bad++; $display("FAIL indr_add1: got %0h expected 12", INDR); end
        idle(); EN_INDR = 1; OPCODE = 5'b00001; OPERAND = 11'h011; PRDATA = 16'h00FF; tick();
        n_cmp++; if (INDR !== 8'h12) begin n_bad++; $display("FAIL indr_hold: got %0h expected 12", INDR); end
    endtask

    task automatic test_hold();
        jump(11'h040);
        idle(); HOLDn = 0; EN_PC = 1; PC_MODE = 2'b01; CALL = 1; OPERAND = 11'h123; tick();
        n_cmp++; if ({PC, STK_EMPTY, STK_ERR} !== {11'h040, 2'b10}) begin n_bad++; $display("FAIL hold_call: got pc=%0h empty=%b err=%b expected pc=40 empty=1 err=0", PC, STK_EMPTY, STK_ERR); end
        idle(); EN_PC = 1; PC_MODE = 2'b11; tick();
        n_cmp++; if ({PC, STK_ERR} !== {11'h041, STK_EN}) begin n_bad++; $display("FAIL hold_ret: got pc=%0h err=%b expected pc=41 err=%b", PC, STK_ERR, STK_EN); end
    endtask

    task automatic test_stack();
`ifdef PARAM_DATAPATH_RET_STACK_EN
        for (int i = 0; i < STACK_DEPTH; i++) begin
            jump(16 + i);
            idle(); EN_PC = 1; PC_MODE = 2'b01; CALL = 1; OPERAND = 11'h100; tick();
            n_cmp++; if (PC !== 11'h100) begin n_bad++; $display("FAIL call%0d: got %0h expected 100", i, PC); end
        end
        n_cmp++; if (STK_FULL !== 1'b1) begin n_bad++; $display("FAIL stk_full: got %b expected 1", STK_FULL); end
        jump(24);
        idle(); EN_PC = 1; PC_MODE = 2'b01; CALL = 1; OPERAND = 11'h100; tick();
        n_cmp++; if ({PC, STK_ERR, STK_FULL} !== {11'h100, 2'b11}) begin n_bad++; $display("FAIL push_full: got pc=%0h err=%b full=%b expected pc=100 err=1 full=1", PC, STK_ERR, STK_FULL); end
        for (int i = 0; i < STACK_DEPTH; i++) begin
            idle(); EN_PC = 1; PC_MODE = 2'b11; tick();
            n_cmp++; if ({PC, STK_ERR} !== {11'(24 - i), 1'b0}) begin n_bad++; $display("FAIL ret%0d: got pc=%0h err=%b expected pc=%0h err=0", i, PC, STK_ERR, 24 - i); end
        end
        n_cmp++; if ({STK_EMPTY, STK_FULL} !== 2'b10) begin n_bad++; $display("FAIL stk_empty: got empty=%b full=%b expected 1/0", STK_EMPTY, STK_FULL); end
        idle(); EN_PC = 1; PC_MODE = 2'b11; tick();
        n_cmp++; if ({PC, STK_ERR} !== {11'h012, 1'b1}) begin n_bad++; $display("FAIL pop_empty: got pc=%0h err=%b expected pc=12 err=1", PC, STK_ERR); end
`else
        jump(5);
        idle(); EN_PC = 1; PC_MODE = 2'b01; CALL = 1; OPERAND = 11'h100; tick();
        n_cmp++; if ({PC, STK_EMPTY} !== {11'h100, 1'b1}) begin n_bad++; $display("FAIL call_off: got pc=%0h empty=%b expected pc=100 empty=1", PC, STK_EMPTY); end
        idle(); EN_PC = 1; PC_MODE = 2'b11; tick();
        n_cmp++; if ({PC, STK_ERR, STK_FULL, STK_EMPTY} !== {11'h101, 3'b001}) begin n_bad++; $display("FAIL ret_off: got pc=%0h err=%b full=%b empty=%b expected pc=101 0/0/1", PC, STK_ERR, STK_FULL, STK_EMPTY); end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            HOLDn = ($urandom_range(0, 9) != 0);
            EN_PC = ($urandom_range(0, 3) != 0);
            PC_MODE = 2'($urandom_range(0, 3));
            CALL = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: OPCODE = 5'b11101;
                1: OPCODE = 5'($urandom_range(24, 25));
                default: OPCODE = 5'($urandom_range(0, 10));
            endcase
            OPERAND = 11'($urandom);
            SEL_OP_MEM = 1'($urandom_range(0, 1));
            EN_IN = 1'($urandom_range(0, 1));
            EN_ACC = 1'($urandom_range(0, 1));
            ACC_SEL = 2'($urandom_range(0, 3));
            EN_INDR = 1'($urandom_range(0, 1));
            PRDATA = 16'($urandom);
            tick();
            n_cmp++; if (PC !== PC_W'(m_pc)) begin n_bad++; $display("FAIL rnd_pc c%0d: got %0h expected %0h", c, PC, m_pc); end
            n_cmp++; if ({PC_OF, PC_UF} !== {m_of, m_uf}) begin n_bad++; $display("FAIL rnd_ofuf c%0d: got %b%b expected %b%b", c, PC_OF, PC_UF, m_of, m_uf); end
            n_cmp++; if (ACC !== DATA_W'(m_acc[ACC_SEL])) begin n_bad++; $display("FAIL rnd_acc c%0d: got %0h expected %0h", c, ACC, m_acc[ACC_SEL]); end
            n_cmp++; if (ZN !== m_zn) begin n_bad++; $display("FAIL rnd_zn c%0d: got %b expected %b", c, ZN, m_zn); end
            n_cmp++; if (INDR !== 8'(m_indr)) begin n_bad++; $display("FAIL rnd_indr c%0d: got %0h expected %0h", c, INDR, m_indr); end
            n_cmp++; if ({STK_ERR, STK_FULL, STK_EMPTY} !== {m_err, m_stk.size() == STACK_DEPTH, m_stk.size() == 0}) begin
                n_bad++; $display("FAIL rnd_stk c%0d: got err/full/empty=%b%b%b expected %b, depth %0d", c, STK_ERR, STK_FULL, STK_EMPTY, m_err, m_stk.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        idle(); ACC_SEL = 3; EN_IN = 1; SEL_OP_MEM = 0; PRDATA = 16'h8001; tick();
        idle(); ACC_SEL = 3; EN_ACC = 1; OPCODE = OP_PASS; EN_PC = 1; PC_MODE = 2'b01; CALL = 1; OPERAND = 11'h200; tick();
        idle(); ACC_SEL = 3; #3;
        RESETn = 0;
        #1;
        n_cmp++; if ({PC, ACC} !== {11'd0, 16'd0}) begin n_bad++; $display("FAIL rst_mid_pc_acc: got pc=%0h acc=%0h expected 0/0", PC, ACC); end
        n_cmp++; if ({ZN, INDR} !== 10'd0) begin n_bad++; $display("FAIL rst_mid_zn_indr: got zn=%b indr=%0h expected 0/0", ZN, INDR); end
        n_cmp++; if ({PC_OF, PC_UF, STK_ERR, STK_FULL, STK_EMPTY} !== 5'b00001) begin n_bad++; $display("FAIL rst_mid_flags: got %b expected 00001", {PC_OF, PC_UF, STK_ERR, STK_FULL, STK_EMPTY}); end
        model_reset();
        @(posedge CLOCK);
        #1;
        RESETn = 1;
        idle(); EN_PC = 1; PC_MODE = 2'b00; tick();
        n_cmp++; if (PC !== 11'd1) begin n_bad++; $display("FAIL post_rst_inc: got %0h expected 1", PC); end
        idle(); EN_PC = 1; PC_MODE = 2'b11; tick();
        n_cmp++; if ({PC, STK_ERR} !== {11'd2, STK_EN}) begin n_bad++; $display("FAIL post_rst_ret: got pc=%0h err=%b expected pc=2 err=%b", PC, STK_ERR, STK_EN); end
    endtask

    initial begin
        test_reset();
        test_pc_wrap();
        test_branch();
        test_acc();
        test_indr();
        test_hold();
        test_stack();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
